// File: rtl/wb_arbiter2.sv
// Two-master, one-slave classic Wishbone arbiter for the TIA/RIOT register bus.
// Round-robin or fixed priority, with a watchdog that force-acks cycles the slave never acks.
module wb_arbiter2 #(
  parameter int unsigned              WB_DATA_WIDTH = 8,
  parameter int unsigned              WB_ADDR_WIDTH = 7,
  parameter int unsigned              FIXED_PRIO    = 0,
  parameter int unsigned              TIMEOUT       = 255,
  parameter logic [WB_DATA_WIDTH-1:0] ERR_DATA      = '1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_dat_i,
  output logic                     m0_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m0_dat_o,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_dat_i,
  output logic                     m1_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m1_dat_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [WB_ADDR_WIDTH-1:0] s_adr_o,
  output logic [WB_DATA_WIDTH-1:0] s_dat_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_dat_i,
  output logic [1:0]               grant_o,
  output logic                     timeout_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [1:0]               r_state;
  logic [7:0]               r_wdog;
  logic                     r_last_grant;
  logic                     r_s_stb;
  logic                     r_s_we;
  logic [WB_ADDR_WIDTH-1:0] r_s_adr;
  logic [WB_DATA_WIDTH-1:0] r_s_dat;
  logic [1:0]               r_grant;
  logic                     r_timeout;
  logic                     r_m0_ack;
  logic                     r_m1_ack;
  logic [WB_DATA_WIDTH-1:0] r_m0_dat;
  logic [WB_DATA_WIDTH-1:0] r_m1_dat;

  logic                     w_any;
  logic                     w_pick1;
  logic                     w_win_we;
  logic [WB_ADDR_WIDTH-1:0] w_win_adr;
  logic [WB_DATA_WIDTH-1:0] w_win_dat;
  logic                     w_expired;
  logic                     w_done;
  logic [WB_DATA_WIDTH-1:0] w_rdata;

  // On a tie, round-robin hands the bus to whichever master did not own it last.
  always_comb begin
    w_any     = m0_stb_i || m1_stb_i;
    w_pick1   = m1_stb_i && (!m0_stb_i || (FIXED_PRIO == 0 && !r_last_grant));
    w_win_we  = w_pick1 ? m1_we_i  : m0_we_i;
    w_win_adr = w_pick1 ? m1_adr_i : m0_adr_i;
    w_win_dat = w_pick1 ? m1_dat_i : m0_dat_i;
    w_expired = (r_wdog == WDOG_LAST);
    w_done    = s_ack_i || w_expired;
    w_rdata   = s_ack_i ? s_dat_i : ERR_DATA;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_wdog       <= '0;
      r_last_grant <= 1'b1;
      r_s_stb      <= 1'b0;
      r_s_we       <= 1'b0;
      r_s_adr      <= '0;
      r_s_dat      <= '0;
      r_grant      <= '0;
      r_timeout    <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_dat     <= '0;
      r_m1_dat     <= '0;
    end else begin
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_s_stb <= 1'b1;
            r_s_we  <= w_win_we;
            r_s_adr <= w_win_adr;
            // Reads leave the slave write-data bus at its previous value.
            if (w_win_we) r_s_dat <= w_win_dat;
            r_grant <= w_pick1 ? 2'b10 : 2'b01;
            r_wdog  <= '0;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_done) begin
            r_s_stb      <= 1'b0;
            r_last_grant <= r_grant[1];
            r_timeout    <= !s_ack_i;
            if (r_grant[1]) r_m1_ack <= 1'b1;
            else            r_m0_ack <= 1'b1;
            if (!r_s_we) begin
              if (r_grant[1]) r_m1_dat <= w_rdata;
              else            r_m0_dat <= w_rdata;
            end
            r_state <= ST_ACK;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        ST_ACK: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_stb_o   = r_s_stb;
  assign s_we_o    = r_s_we;
  assign s_adr_o   = r_s_adr;
  assign s_dat_o   = r_s_dat;
  assign grant_o   = r_grant;
  assign timeout_o = r_timeout;
  assign m0_ack_o  = r_m0_ack;
  assign m1_ack_o  = r_m1_ack;
  assign m0_dat_o  = r_m0_dat;
  assign m1_dat_o  = r_m1_dat;

endmodule
